// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests,
// per-side ack/err pulses, read data, occupancy and status flags.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;

  // FIFO side
  modport slave (
    input  flush, wr_en, din, rd_en,
    output wr_ack, wr_err, rd_ack, rd_err, dout, count,
           full, empty, almost_full, almost_empty
  );

  // Producer/consumer side
  modport master (
    output flush, wr_en, din, rd_en,
    input  wr_ack, wr_err, rd_ack, rd_err, dout, count,
           full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost thresholds,
// live occupancy, synchronous flush and optional first-word-fall-through.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input logic               clk,
  input logic               clear_n,
  sync_fifo_param_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_wr_ack;
  logic              r_wr_err;
  logic              r_rd_ack;
  logic              r_rd_err;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_wr_ok;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // A write into a full FIFO is allowed when a read frees a slot this cycle.
  assign w_rd_ok = bus.rd_en && !w_empty;
  assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok);

  // Pointers, occupancy and handshake pulses; flush overrides any request.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= bus.wr_en && !w_wr_ok;
      r_rd_ack <= w_rd_ok;
      r_rd_err <= bus.rd_en && !w_rd_ok;
      if (w_wr_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_ok) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (!bus.flush && w_wr_ok) r_mem[r_wr_ptr] <= bus.din;
  end

  // Registered read data for standard mode; holds between accepted reads.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                   r_dout <= '0;
    else if (!bus.flush && w_rd_ok) r_dout <= r_mem[r_rd_ptr];
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented as soon as it is stored.
      assign bus.dout = r_mem[r_rd_ptr];
    end else begin : g_std
      assign bus.dout = r_dout;
    end
  endgenerate

  assign bus.wr_ack       = r_wr_ack;
  assign bus.wr_err       = r_wr_err;
  assign bus.rd_ack       = r_rd_ack;
  assign bus.rd_err       = r_rd_err;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CNT_W'(AE_THRESH));
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (16-deep standard, 5-deep
// standard, 16-deep FWFT) share one stimulus stream and are compared each
// cycle against a queue-style occupancy model.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       clear_n;
  logic       flush, wr_en, rd_en;
  logic [7:0] din;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) u_if0 ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(5))  u_if1 ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) u_if2 ();

  assign u_if0.flush = flush; assign u_if0.wr_en = wr_en;
  assign u_if0.rd_en = rd_en; assign u_if0.din   = din;
  assign u_if1.flush = flush; assign u_if1.wr_en = wr_en;
  assign u_if1.rd_en = rd_en; assign u_if1.din   = din;
  assign u_if2.flush = flush; assign u_if2.wr_en = wr_en;
  assign u_if2.rd_en = rd_en; assign u_if2.din   = din;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
    u_dut0 (.clk(clk), .clear_n(clear_n), .bus(u_if0));
  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0))
    u_dut1 (.clk(clk), .clear_n(clear_n), .bus(u_if1));
  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
    u_dut2 (.clk(clk), .clear_n(clear_n), .bus(u_if2));

  // Reference model: circular store with head index and size per instance.
  logic [7:0] mm [3][16];
  int         mh [3];
  int         ms [3];
  logic [7:0] e_dout [3];
  logic       e_wa [3], e_we [3], e_ra [3], e_re [3];

  function automatic int dep(input int k);
    return (k == 1) ? 5 : 16;
  endfunction

  function automatic bit is_fwft(input int k);
    return (k == 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; ms[k] = 0; e_dout[k] = 8'h00;
      e_wa[k] = 0; e_we[k] = 0; e_ra[k] = 0; e_re[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (flush) begin
        mh[k] = 0; ms[k] = 0;
        e_wa[k] = 0; e_we[k] = 0; e_ra[k] = 0; e_re[k] = 0;
      end else begin
        bit rok, wok;
        rok = rd_en && (ms[k] > 0);
        wok = wr_en && ((ms[k] < dep(k)) || rok);
        e_wa[k] = wok; e_we[k] = wr_en && !wok;
        e_ra[k] = rok; e_re[k] = rd_en && !rok;
        if (rok) begin
          if (!is_fwft(k)) e_dout[k] = mm[k][mh[k]];
          mh[k] = (mh[k] + 1) % dep(k);
          ms[k] = ms[k] - 1;
        end
        if (wok) begin
          mm[k][(mh[k] + ms[k]) % dep(k)] = din;
          ms[k] = ms[k] + 1;
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] cnt, input logic full,
                          input logic empty, input logic af, input logic ae,
                          input logic wa, input logic we, input logic ra,
                          input logic re, input logic [7:0] dout);
    int d;
    d = dep(k);
    chk($sformatf("i%0d.count", k), cnt, ms[k]);
    chk($sformatf("i%0d.full", k), full, (ms[k] == d));
    chk($sformatf("i%0d.empty", k), empty, (ms[k] == 0));
    chk($sformatf("i%0d.almost_full", k), af, (ms[k] >= d - 2));
    chk($sformatf("i%0d.almost_empty", k), ae, (ms[k] <= 2));
    chk($sformatf("i%0d.wr_ack", k), wa, e_wa[k]);
    chk($sformatf("i%0d.wr_err", k), we, e_we[k]);
    chk($sformatf("i%0d.rd_ack", k), ra, e_ra[k]);
    chk($sformatf("i%0d.rd_err", k), re, e_re[k]);
    if (!is_fwft(k))
      chk($sformatf("i%0d.dout", k), dout, e_dout[k]);
    else if (ms[k] > 0)
      chk($sformatf("i%0d.dout_head", k), dout, mm[k][mh[k]]);
  endtask

  task automatic compare_all();
    cmp_inst(0, 32'(u_if0.count), u_if0.full, u_if0.empty, u_if0.almost_full,
             u_if0.almost_empty, u_if0.wr_ack, u_if0.wr_err, u_if0.rd_ack,
             u_if0.rd_err, u_if0.dout);
    cmp_inst(1, 32'(u_if1.count), u_if1.full, u_if1.empty, u_if1.almost_full,
             u_if1.almost_empty, u_if1.wr_ack, u_if1.wr_err, u_if1.rd_ack,
             u_if1.rd_err, u_if1.dout);
    cmp_inst(2, 32'(u_if2.count), u_if2.full, u_if2.empty, u_if2.almost_full,
             u_if2.almost_empty, u_if2.wr_ack, u_if2.wr_err, u_if2.rd_ack,
             u_if2.rd_err, u_if2.dout);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic f, input logic w, input logic r, input logic [7:0] d);
    flush = f; wr_en = w; rd_en = r; din = d;
  endtask

  initial begin
    clear_n = 1'b0;
    drive(0, 0, 0, 8'h00);
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset.count", 32'(u_if0.count), 0);
    chk("reset.empty", u_if0.empty, 1);
    chk("reset.almost_empty", u_if0.almost_empty, 1);
    chk("reset.full", u_if0.full, 0);
    chk("reset.dout", u_if0.dout, 8'h00);
    clear_n = 1'b1;
    tick();

    // Fill 16 words plus one rejected write; watch threshold rising edges.
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 0, 8'(i));
      tick();
      if (i < 16) begin
        chk("fill.wr_ack", u_if0.wr_ack, 1);
        chk("fill.count", 32'(u_if0.count), i + 1);
        chk("fill.almost_empty", u_if0.almost_empty, (i + 1) <= 2);
        chk("fill.almost_full", u_if0.almost_full, (i + 1) >= 14);
      end
    end
    chk("fill17.wr_err", u_if0.wr_err, 1);
    chk("fill17.wr_ack", u_if0.wr_ack, 0);
    chk("fill17.full", u_if0.full, 1);
    chk("fill17.count", 32'(u_if0.count), 16);

    // Drain in order, then one rejected read; threshold falling edges.
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 8'h00);
      tick();
      if (i < 16) begin
        chk("drain.rd_ack", u_if0.rd_ack, 1);
        chk("drain.dout", u_if0.dout, i);
        chk("drain.almost_full", u_if0.almost_full, (15 - i) >= 14);
        chk("drain.almost_empty", u_if0.almost_empty, (15 - i) <= 2);
      end
    end
    chk("drain17.rd_err", u_if0.rd_err, 1);
    chk("drain17.empty", u_if0.empty, 1);

    // Refill, then read+write together while full.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 8'(8'h10 + i));
      tick();
    end
    drive(0, 1, 1, 8'hA5);
    tick();
    chk("rw_full.wr_ack", u_if0.wr_ack, 1);
    chk("rw_full.rd_ack", u_if0.rd_ack, 1);
    chk("rw_full.count", 32'(u_if0.count), 16);
    chk("rw_full.dout", u_if0.dout, 8'h10);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 8'h00);
      tick();
      chk("rw_drain.dout", u_if0.dout, (i == 15) ? 8'hA5 : 8'(8'h11 + i));
    end

    // 5-deep wrap: fill, then 12 simultaneous write/read pairs.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 8'(8'h30 + i));
      tick();
    end
    chk("wrap.full", u_if1.full, 1);
    for (int j = 0; j < 12; j++) begin
      drive(0, 1, 1, 8'(8'h40 + j));
      tick();
      chk("wrap.rd_ack", u_if1.rd_ack, 1);
      chk("wrap.wr_ack", u_if1.wr_ack, 1);
      chk("wrap.count", 32'(u_if1.count), 5);
      chk("wrap.dout", u_if1.dout, (j < 5) ? 8'(8'h30 + j) : 8'(8'h40 + j - 5));
    end
    drive(1, 0, 0, 8'h00);
    tick();

    // FWFT head visibility before rd_en.
    drive(0, 1, 0, 8'h3C);
    tick();
    chk("fwft.dout", u_if2.dout, 8'h3C);
    chk("fwft.empty", u_if2.empty, 0);
    drive(0, 0, 1, 8'h00);
    tick();
    chk("fwft.rd_ack", u_if2.rd_ack, 1);
    chk("fwft.empty_after", u_if2.empty, 1);

    // Flush at count 7 with a concurrent write.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 8'(8'h50 + i));
      tick();
    end
    chk("flush.pre_count", 32'(u_if0.count), 7);
    drive(1, 1, 0, 8'h77);
    tick();
    chk("flush.count", 32'(u_if0.count), 0);
    chk("flush.wr_ack", u_if0.wr_ack, 0);
    chk("flush.dout", u_if0.dout, 8'h3C);

    // Randomized traffic with alternating write/read bias and rare flushes.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 200) % 2 == 1) ? 30 : 75;
      drive(($urandom % 128) == 0, ($urandom % 100) < wp,
            ($urandom % 100) < (105 - wp), 8'($urandom));
      tick();
    end

    // Asynchronous reset mid-cycle at count 9.
    drive(1, 0, 0, 8'h00);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 8'(8'h60 + i));
      tick();
    end
    chk("areset.pre_count", 32'(u_if0.count), 9);
    drive(0, 1, 0, 8'h69);
    @(posedge clk);
    model_edge();
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    chk("areset.count", 32'(u_if0.count), 0);
    chk("areset.empty", u_if0.empty, 1);
    chk("areset.almost_empty", u_if0.almost_empty, 1);
    chk("areset.full", u_if0.full, 0);
    chk("areset.almost_full", u_if0.almost_full, 0);
    chk("areset.wr_ack", u_if0.wr_ack, 0);
    chk("areset.dout", u_if0.dout, 8'h00);
    compare_all();
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    compare_all();
    clear_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that succeeds the dual-clock FIFO in the verification environment. It keeps the same handshake family (ack/err per side, full/empty, almost_full/almost_empty). It adds:
- configurable data width and depth, including non-power-of-two depths;
- programmable almost thresholds;
- a live occupancy count;
- synchronous flush;
- a first-word-fall-through (FWFT) read mode.

It sits between producer and consumer logic that share one clock domain.

## Interface
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage entries (>=2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode
- clk  in  1  single clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush, empties FIFO
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- wr_ack  out  1  write accepted (registered pulse)
- wr_err  out  1  write rejected (registered pulse)
- rd_ack  out  1  read accepted (registered pulse)
- rd_err  out  1  read rejected (registered pulse)
- dout  out  DATA_W  read data
- count  out  $clog2(DEPTH+1)  registered occupancy
- full, empty, almost_full, almost_empty  out  1 each  status flags

## Operation
- Acceptance is evaluated on registered state at each rising edge:
  - rd_ok = rd_en && !empty
  - wr_ok = wr_en && (!full || rd_ok)
- Write when full is accepted only if a read is accepted in the same cycle.
- Read when empty is always rejected. There is no write-to-read bypass, even in FWFT mode.
- Accepted write: mem[wr_ptr] <= din; wr_ptr advances.
- Accepted read: rd_ptr advances.
- Pointers run 0..DEPTH-1. DEPTH-1 wraps to 0 by explicit compare, not by binary overflow.
- count update per edge:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither are accepted
- Flags, combinational from registered count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count>=AF_THRESH)
  - almost_empty = (count<=AE_THRESH)
- flush has priority over everything:
  - next edge: count=0, wr_ptr=rd_ptr=0
  - wr_en/rd_en in that cycle are ignored; no ack or err is generated
  - dout holds its value
- Standard mode (FWFT=0):
  - dout <= mem[rd_ptr] on an accepted read
  - otherwise dout holds its last value
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] continuously while !empty, so the head word is visible before rd_en
  - rd_en pops it; dout is don't-care while empty
- Reset (clear_n low, asynchronous, any time including mid-transfer):
  - count=0, pointers=0
  - wr_ack/wr_err/rd_ack/rd_err=0, dout=0 (standard mode)
  - empty=1, almost_empty=1, full=0, almost_full=0
- Memory contents are not reset.
- Reset is released synchronously to the design (deassertion synchronised externally).

## Timing
- wr_ack/wr_err are asserted for exactly one cycle, on the edge after the request cycle:
  - wr_ack if the write was accepted
  - wr_err if wr_en was high but rejected
- rd_ack/rd_err follow the same rule for reads.
- Standard mode: read latency is 1 cycle; dout is valid in the same cycle rd_ack is high.
- FWFT mode: head data is valid 1 cycle after the first write into an empty FIFO (count becomes 1).
- Flags and count reflect an accepted operation 1 cycle after the request edge.
- Back-to-back operations every cycle are supported on both sides, full throughput.
- Simultaneous read+write at any occupancy (including full) sustains one word per cycle, with count constant.

## Test plan
- Reset then fill with DATA_W=8, DEPTH=16:
  - write 0x00..0x0F on 16 consecutive cycles, then a 17th write
  - expect 16 wr_ack pulses; full=1 after the 16th; count=16; the 17th write gives wr_err=1 and no data change
  - then 16 reads return 0x00..0x0F in order with rd_ack; a 17th read gives rd_err=1; empty=1
- Thresholds with AF_THRESH=14, AE_THRESH=2:
  - almost_empty drops when count goes 2->3
  - almost_full rises when count goes 13->14; verify both edges while draining
- Full with simultaneous read+write (count=16, wr_en=rd_en=1, din=0xA5):
  - wr_ack and rd_ack both high; count stays 16
  - 0xA5 is read out as the 16th word after the older 15
- Non-power-of-two wrap with DEPTH=5:
  - 12 interleaved write/read pairs
  - data order preserved across 2+ pointer wraps; count never exceeds 5
- FWFT=1:
  - write 0x3C into an empty FIFO; dout=0x3C one cycle later, before any rd_en
  - rd_en pops it; rd_ack next cycle; empty=1
- Flush and reset mid-operation:
  - at count=7, assert flush with wr_en=1: count=0, no wr_ack, dout unchanged
  - at count=9, pulse clear_n low mid-cycle: all outputs reach their reset values immediately, without waiting for a clock edge
